// File: rtl/mem_arb_pkg.sv
// Shared types for the DataMem port arbiter (mem_port_arbiter).
// Optional round-robin arbitration is enabled with the MEM_ARB_RR_EN macro.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
  typedef enum logic {GNT_D, GNT_I} grant_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;
  localparam logic [2:0] FUNCT3_WORD = 3'b010;
endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between the D and I requesters for mem_port_arbiter.
// MEM_ARB_RR_EN defined: round-robin on conflict; undefined: D always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_d_req,
  input  logic   i_i_req,
  input  grant_t i_last_grant,
  output logic   o_valid,
  output grant_t o_winner
);

`ifndef MEM_ARB_RR_EN
  // Fixed priority still receives last_grant so the port list is build-independent.
  logic w_unused_last;
  assign w_unused_last = (i_last_grant == GNT_I);
`endif

  always_comb begin
    o_valid  = i_d_req | i_i_req;
    o_winner = GNT_D;
    if (i_d_req && i_i_req) begin
`ifdef MEM_ARB_RR_EN
      o_winner = (i_last_grant == GNT_D) ? GNT_I : GNT_D;
`else
      o_winner = GNT_D;
`endif
    end else if (i_i_req) begin
      o_winner = GNT_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the DataMem port between the D and I cache requesters, one transaction at a time.
// Arbitration policy on conflict selected by MEM_ARB_RR_EN (see mem_arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [2:0]            d_funct3,
  output logic                  d_ready,
  output logic [DATA_WIDTH-1:0] d_rdata,
  input  logic                  i_read,
  input  logic [DATA_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t            r_state;
  logic [CNT_W-1:0]      r_cnt;
  grant_t                r_last_grant;
  grant_t                r_gnt;
  op_t                   r_op;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [DATA_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [2:0]            r_mem_funct3;
  logic                  r_d_ready;
  logic                  r_i_ready;
  logic [DATA_WIDTH-1:0] r_d_rdata;
  logic [DATA_WIDTH-1:0] r_i_rdata;
  logic                  r_busy;

  logic   w_valid;
  grant_t w_winner;

  mem_arb_pick u_pick (
    .i_d_req      (d_read | d_write),
    .i_i_req      (i_read),
    .i_last_grant (r_last_grant),
    .o_valid      (w_valid),
    .o_winner     (w_winner)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= GNT_I;
      r_gnt        <= GNT_D;
      r_op         <= OP_READ;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_funct3 <= '0;
      r_d_ready    <= 1'b0;
      r_i_ready    <= 1'b0;
      r_d_rdata    <= '0;
      r_i_rdata    <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_d_ready <= 1'b0;
      r_i_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          r_d_rdata <= '0;
          r_i_rdata <= '0;
          if (w_valid) begin
            r_state      <= ACCESS;
            r_busy       <= 1'b1;
            r_cnt        <= CNT_LOAD;
            r_gnt        <= w_winner;
            r_last_grant <= w_winner;
            if (w_winner == GNT_D) begin
              // A simultaneous read+write is executed as a write.
              r_op         <= d_write ? OP_WRITE : OP_READ;
              r_mem_addr   <= d_addr;
              r_mem_wdata  <= d_wdata;
              r_mem_funct3 <= d_funct3;
              r_mem_read   <= !d_write;
              r_mem_write  <= d_write && (LATENCY == 1);
            end else begin
              r_op         <= OP_READ;
              r_mem_addr   <= i_addr;
              r_mem_wdata  <= '0;
              r_mem_funct3 <= FUNCT3_WORD;
              r_mem_read   <= 1'b1;
              r_mem_write  <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            r_state     <= RESP;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_gnt == GNT_D) begin
              r_d_ready <= 1'b1;
              r_d_rdata <= (r_op == OP_READ) ? mem_rdata : '0;
            end else begin
              r_i_ready <= 1'b1;
              r_i_rdata <= mem_rdata;
            end
          end else begin
            r_cnt       <= r_cnt - CNT_ONE;
            // Write strobe lands only in the final ACCESS cycle.
            r_mem_write <= (r_op == OP_WRITE) && (r_cnt == CNT_ONE);
          end
        end
        RESP: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_d_rdata <= '0;
          r_i_rdata <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign d_ready    = r_d_ready;
  assign d_rdata    = r_d_rdata;
  assign i_ready    = r_i_ready;
  assign i_rdata    = r_i_rdata;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_funct3 = r_mem_funct3;
  assign busy       = r_busy;

endmodule
